keypad_entry_ctrl: RTL and testbench
====================================

Name: keypad_entry_ctrl

Overview:
Sequencing controller between the matrix keyboard scanner and the 4-digit seven-segment driver. Turns raw scanner key events into an edited 4-digit BCD entry (digits, backspace, clear, enter) and drives the display's BCD, DOT and BI inputs. Commits the finished value to downstream logic with a one-cycle valid pulse. Sits at top level beside Keyboard and SevenSegs and replaces ad-hoc press counting.

Parameters:
DEBOUNCE_CYC, 50000, clk cycles after an accepted event during which further events are ignored
TIMEOUT_CYC, 250000000, idle clk cycles in ENTRY before the entry is discarded
BLINK_CYC, 12500000, half-period in clk cycles of the cursor blink (used only with the optional feature)

Ports:
clk  in  1  system clock; all logic on its rising edge
reset  in  1  asynchronous active-low reset; 0 resets every register
key_num  in  4  key code from the scanner; valid while key_pressed=1
key_pressed  in  1  scanner key-down level; asynchronous to clk
bcd_out  out  16  to SevenSegs BCD; [3:0] is the rightmost digit
dot_out  out  4  to SevenSegs DOT; cursor marker
bi_out  out  1  to SevenSegs BI; 1 blanks the display
value_out  out  16  last committed BCD value
value_valid  out  1  one-cycle pulse when value_out is updated
digit_count  out  3  digits currently entered, 0..4
overflow  out  1  one-cycle pulse: digit key rejected because the buffer is full
timeout  out  1  one-cycle pulse: entry discarded by timeout
press_cnt  out  4  accepted-event counter; wraps 15->0

Behaviour:
- Reset values: bcd_out=0, dot_out=0, bi_out=0, value_out=0, value_valid=0, digit_count=0, overflow=0, timeout=0, press_cnt=0. State=IDLE. Hold-off, timeout and blink counters=0.
- Input path: key_pressed passes through a 2-FF synchronizer. A rising edge of the synchronized signal while the hold-off counter is 0 produces key_evt, and key_num is captured in the same cycle. key_evt loads the hold-off counter with DEBOUNCE_CYC-1. Events during hold-off are dropped and do not count.
- Latency: the registered outputs reflect a key 3 rising edges after the first edge that samples key_pressed=1.
- Every key_evt increments press_cnt. This includes keys that have no other effect.
- Key codes: 0-9 are digits, A is backspace, B is clear, C is enter, D-F are ignored.
- IDLE:
  - bcd_out=value_out, dot_out=0000, bi_out=0.
  - A digit loads buf={12'h000,d}, sets digit_count=1 and moves to ENTRY.
  - A, B, C and D-F have no effect.
- ENTRY:
  - bcd_out=buf. dot_out is one-hot at digit index digit_count-1 (0001 when count=1).
  - Digit with count<4: buf={buf[11:0],d}, count+1.
  - Digit with count=4: buf unchanged and a one-cycle overflow pulse.
  - A: buf={4'h0,buf[15:4]}, count-1. When count reaches 0, go to IDLE.
  - B: buf=0, count=0, go to IDLE. value_out is unchanged.
  - C: value_out<=buf, value_valid pulses for 1 cycle, count=0, go to IDLE.
  - The timeout counter reloads on every key_evt. When it expires: buf=0, count=0, a one-cycle timeout pulse, go to IDLE.
- Simultaneous key_evt and timer expiry: key_evt wins and the timer reloads.
- Reset asserted mid-entry: the entry is lost and all outputs take their reset values asynchronously.
- Pulses never overlap. At most one of value_valid, overflow or timeout is high in any cycle.

Optional Feature:
CURSOR_BLINK_EN:
- Defined: in ENTRY the cursor dot toggles every BLINK_CYC cycles. The phase restarts to "on" at each key_evt.
- Undefined: the cursor dot is steady. The blink counter is not synthesized.

Decomposition:
- Package keypad_pkg holds:
  - key code constants KEY_BKSP=4'hA, KEY_CLR=4'hB, KEY_ENT=4'hC;
  - the state encoding IDLE=1'b0, ENTRY=1'b1;
  - the BCD word width constant 16.
- One sub-module, key_event_sync: 2-FF synchronizer, edge detect, hold-off counter, key_num capture. Outputs key_evt and key_code.

Test Plan (bench uses DEBOUNCE_CYC=4, TIMEOUT_CYC=100, BLINK_CYC=8):
- Press 1,2,3,C with gaps of at least 6 cycles -> bcd_out 0x0001, 0x0012, 0x0123; then a value_valid pulse with value_out=0x0123, IDLE, press_cnt=4.
- Press 5,6,7,8,9 -> the fifth press pulses overflow, bcd_out stays 0x5678, digit_count=4, dot_out=1000.
- From entry 0x0042, press A, A -> 0x0004 then IDLE with bcd_out=value_out. A further A changes nothing except press_cnt.
- Enter 7, then wait 100 cycles idle -> timeout pulse, IDLE, value_out unchanged. Also a key on the exact expiry cycle -> no timeout, entry updated.
- Toggle key_pressed twice within 3 cycles -> only one event, press_cnt+1. Also 16 accepted presses -> press_cnt wraps to 0.
- Assert reset during ENTRY with buf=0x0034 -> all outputs 0 immediately, no value_valid.

Source files
------------

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared constants and types for the keypad entry controller
//
// Purpose : key code constants, FSM state encoding, BCD word width and a
//           digit classifier shared by keypad_entry_ctrl and its sub-module.
// Ports   : none (package).

package keypad_pkg;

  localparam int BCD_W = 16;

  localparam logic [3:0] KEY_BKSP = 4'hA;
  localparam logic [3:0] KEY_CLR  = 4'hB;
  localparam logic [3:0] KEY_ENT  = 4'hC;

  typedef enum logic {
    IDLE  = 1'b0,
    ENTRY = 1'b1
  } state_e;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/key_event_sync.sv
// rtl/key_event_sync.sv - key-down synchronizer, edge detect and hold-off
//
// Purpose : brings the asynchronous scanner key-down level into the clk
//           domain, turns its rising edge into a single-cycle key_evt and
//           suppresses further events for DEBOUNCE_CYC cycles.
// Ports   : clk, reset (async, active low)
//           key_num[3:0]  scanner key code, stable while key_pressed=1
//           key_pressed   scanner key-down level (asynchronous)
//           key_evt       one-cycle accepted key event
//           key_code[3:0] key code belonging to key_evt

module key_event_sync #(
  parameter int DEBOUNCE_CYC = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] key_num,
  input  logic       key_pressed,
  output logic       key_evt,
  output logic [3:0] key_code
);

  localparam int HW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  logic          sync1_q, sync2_q, prev_q;
  logic [HW-1:0] hold_q;
  logic [3:0]    code_q;

  // The rising edge is seen on sync2 one cycle after sync1; key_num is
  // captured on the edge where sync1 rises so it is ready with key_evt.
  assign key_evt  = sync2_q & ~prev_q & (hold_q == '0);
  assign key_code = code_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      hold_q  <= '0;
      code_q  <= '0;
    end else begin
      sync1_q <= key_pressed;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      if (sync1_q && !sync2_q) begin
        code_q <= key_num;
      end
      if (key_evt) begin
        hold_q <= HW'(DEBOUNCE_CYC - 1);
      end else if (hold_q != '0) begin
        hold_q <= hold_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/keypad_entry_ctrl.sv
// rtl/keypad_entry_ctrl.sv - 4-digit BCD keypad entry editor and commit logic
//
// Purpose : edits a 4-digit BCD entry from scanner key events (digits,
//           backspace, clear, enter), drives the seven-segment BCD/DOT/BI
//           inputs and commits the entry with a one-cycle value_valid.
// Ports   : clk, reset (async, active low)
//           key_num[3:0], key_pressed          from the keyboard scanner
//           bcd_out[15:0], dot_out[3:0], bi_out to the seven-segment driver
//           value_out[15:0], value_valid       committed value and strobe
//           digit_count[2:0]                   digits held in the entry
//           overflow, timeout                  one-cycle status pulses
//           press_cnt[3:0]                     accepted-event counter
// Config  : define CURSOR_BLINK_EN to blink the cursor dot in ENTRY.

module keypad_entry_ctrl
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 50000,
  parameter int TIMEOUT_CYC  = 250000000,
  parameter int BLINK_CYC    = 12500000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       key_num,
  input  logic             key_pressed,
  output logic [BCD_W-1:0] bcd_out,
  output logic [3:0]       dot_out,
  output logic             bi_out,
  output logic [BCD_W-1:0] value_out,
  output logic             value_valid,
  output logic [2:0]       digit_count,
  output logic             overflow,
  output logic             timeout,
  output logic [3:0]       press_cnt
);

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic       key_evt;
  logic [3:0] key_code;
  logic       cursor_on;

  state_e           state_q, state_d;
  logic [BCD_W-1:0] buf_q, buf_d, value_q, value_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             vv_q, vv_d, ov_q, ov_d, to_q, to_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic [3:0]       press_q, press_d;

  key_event_sync #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_key_event_sync (
    .clk         (clk),
    .reset       (reset),
    .key_num     (key_num),
    .key_pressed (key_pressed),
    .key_evt     (key_evt),
    .key_code    (key_code)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      buf_q   <= '0;
      value_q <= '0;
      cnt_q   <= '0;
      vv_q    <= 1'b0;
      ov_q    <= 1'b0;
      to_q    <= 1'b0;
      tmr_q   <= '0;
      press_q <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      value_q <= value_d;
      cnt_q   <= cnt_d;
      vv_q    <= vv_d;
      ov_q    <= ov_d;
      to_q    <= to_d;
      tmr_q   <= tmr_d;
      press_q <= press_d;
    end
  end

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    value_d = value_q;
    cnt_d   = cnt_q;
    vv_d    = 1'b0;
    ov_d    = 1'b0;
    to_d    = 1'b0;
    tmr_d   = tmr_q;
    press_d = press_q;

    // A key event takes priority over a timer expiring in the same cycle.
    if (key_evt) begin
      press_d = press_q + 4'd1;
      tmr_d   = TW'(TIMEOUT_CYC - 1);
      case (state_q)
        IDLE: begin
          if (is_digit(key_code)) begin
            buf_d   = {12'h000, key_code};
            cnt_d   = 3'd1;
            state_d = ENTRY;
          end
        end
        default: begin
          if (is_digit(key_code)) begin
            if (cnt_q == 3'd4) begin
              ov_d = 1'b1;
            end else begin
              buf_d = {buf_q[11:0], key_code};
              cnt_d = cnt_q + 3'd1;
            end
          end else begin
            case (key_code)
              KEY_BKSP: begin
                buf_d = {4'h0, buf_q[15:4]};
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                  state_d = IDLE;
                end
              end
              KEY_CLR: begin
                buf_d   = '0;
                cnt_d   = '0;
                state_d = IDLE;
              end
              KEY_ENT: begin
                value_d = buf_q;
                vv_d    = 1'b1;
                buf_d   = '0;
                cnt_d   = '0;
                state_d = IDLE;
              end
              default: ;
            endcase
          end
        end
      endcase
    end else if (state_q == ENTRY) begin
      if (tmr_q == '0) begin
        buf_d   = '0;
        cnt_d   = '0;
        to_d    = 1'b1;
        state_d = IDLE;
      end else begin
        tmr_d = tmr_q - 1'b1;
      end
    end
  end

`ifdef CURSOR_BLINK_EN
  localparam int BW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;

  logic [BW-1:0] blink_cnt_q;
  logic          blink_on_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
    end else if (key_evt) begin
      blink_cnt_q <= BW'(BLINK_CYC - 1);
      blink_on_q  <= 1'b1;
    end else if (state_q == ENTRY) begin
      if (blink_cnt_q == '0) begin
        blink_cnt_q <= BW'(BLINK_CYC - 1);
        blink_on_q  <= ~blink_on_q;
      end else begin
        blink_cnt_q <= blink_cnt_q - 1'b1;
      end
    end
  end

  assign cursor_on = blink_on_q;
`else
  assign cursor_on = 1'b1;
`endif

  // In ENTRY the count is always 1..4, so the cursor shift never underflows.
  assign bcd_out     = (state_q == ENTRY) ? buf_q : value_q;
  assign dot_out     = (state_q == ENTRY) ? ((4'b0001 << (cnt_q - 3'd1)) & {4{cursor_on}})
                                          : 4'b0000;
  assign bi_out      = 1'b0;
  assign value_out   = value_q;
  assign value_valid = vv_q;
  assign digit_count = cnt_q;
  assign overflow    = ov_q;
  assign timeout     = to_q;
  assign press_cnt   = press_q;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// tb/tb_keypad_entry_ctrl.sv - self-checking bench for keypad_entry_ctrl

module tb_keypad_entry_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  key_num;
  logic        key_pressed;
  logic [15:0] bcd_out;
  logic [3:0]  dot_out;
  logic        bi_out;
  logic [15:0] value_out;
  logic        value_valid;
  logic [2:0]  digit_count;
  logic        overflow;
  logic        timeout;
  logic [3:0]  press_cnt;

  keypad_entry_ctrl #(
    .DEBOUNCE_CYC (4),
    .TIMEOUT_CYC  (100),
    .BLINK_CYC    (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .key_num     (key_num),
    .key_pressed (key_pressed),
    .bcd_out     (bcd_out),
    .dot_out     (dot_out),
    .bi_out      (bi_out),
    .value_out   (value_out),
    .value_valid (value_valid),
    .digit_count (digit_count),
    .overflow    (overflow),
    .timeout     (timeout),
    .press_cnt   (press_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  key;
    logic [15:0] bcd;
    logic [3:0]  dot;
    logic [2:0]  cnt;
    logic [15:0] val;
    logic        vv;
    logic        ov;
    logic        to;
  } vec_t;

  vec_t       tbl[17];
  vec_t       exp_q[$];
  logic [3:0] exp_press;
  int         n_chk;
  int         n_fail;

  function automatic vec_t mk(input logic [3:0] k, input logic [15:0] b, input logic [3:0] d,
                              input logic [2:0] c, input logic [15:0] v, input logic vv,
                              input logic ov, input logic to);
    vec_t r;
    r.key = k; r.bcd = b; r.dot = d; r.cnt = c; r.val = v; r.vv = vv; r.ov = ov; r.to = to;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_front(input string tag);
    vec_t e;
    if (exp_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s scoreboard_empty: got 0 entries expected 1", tag);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, ".bcd"},   bcd_out, e.bcd);
    chk({tag, ".dot"},   16'(dot_out), 16'(e.dot));
    chk({tag, ".cnt"},   16'(digit_count), 16'(e.cnt));
    chk({tag, ".val"},   value_out, e.val);
    chk({tag, ".vv"},    16'(value_valid), 16'(e.vv));
    chk({tag, ".ov"},    16'(overflow), 16'(e.ov));
    chk({tag, ".to"},    16'(timeout), 16'(e.to));
    chk({tag, ".bi"},    16'(bi_out), 16'(0));
    chk({tag, ".press"}, 16'(press_cnt), 16'(exp_press));
  endtask

  task automatic check_no_pulse(input string tag);
    chk({tag, ".vv_off"}, 16'(value_valid), 16'(0));
    chk({tag, ".ov_off"}, 16'(overflow), 16'(0));
    chk({tag, ".to_off"}, 16'(timeout), 16'(0));
  endtask

  // Drive a key at a falling edge and stop just after the third rising edge,
  // which is where the registered outputs first reflect the key.
  task automatic send_only(input vec_t v);
    exp_q.push_back(v);
    @(negedge clk);
    key_num     = v.key;
    key_pressed = 1'b1;
    exp_press   = exp_press + 4'd1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v, input string tag);
    send_only(v);
    compare_front(tag);
    key_pressed = 1'b0;
    @(posedge clk);
    #1;
    check_no_pulse(tag);
    repeat (6) @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk       = 0;
    n_fail      = 0;
    exp_press   = 4'd0;
    reset       = 1'b0;
    key_num     = 4'd0;
    key_pressed = 1'b0;

    tbl[0]  = mk(4'h1, 16'h0001, 4'b0001, 3'd1, 16'h0000, 1'b0, 1'b0, 1'b0);
    tbl[1]  = mk(4'h2, 16'h0012, 4'b0010, 3'd2, 16'h0000, 1'b0, 1'b0, 1'b0);
    tbl[2]  = mk(4'h3, 16'h0123, 4'b0100, 3'd3, 16'h0000, 1'b0, 1'b0, 1'b0);
    tbl[3]  = mk(4'hC, 16'h0123, 4'b0000, 3'd0, 16'h0123, 1'b1, 1'b0, 1'b0);
    tbl[4]  = mk(4'h5, 16'h0005, 4'b0001, 3'd1, 16'h0123, 1'b0, 1'b0, 1'b0);
    tbl[5]  = mk(4'h6, 16'h0056, 4'b0010, 3'd2, 16'h0123, 1'b0, 1'b0, 1'b0);
    tbl[6]  = mk(4'h7, 16'h0567, 4'b0100, 3'd3, 16'h0123, 1'b0, 1'b0, 1'b0);
    tbl[7]  = mk(4'h8, 16'h5678, 4'b1000, 3'd4, 16'h0123, 1'b0, 1'b0, 1'b0);
    tbl[8]  = mk(4'h9, 16'h5678, 4'b1000, 3'd4, 16'h0123, 1'b0, 1'b1, 1'b0);
    tbl[9]  = mk(4'hB, 16'h0123, 4'b0000, 3'd0, 16'h0123, 1'b0, 1'b0, 1'b0);
    tbl[10] = mk(4'h4, 16'h0004, 4'b0001, 3'd1, 16'h0123, 1'b0, 1'b0, 1'b0);
    tbl[11] = mk(4'h2, 16'h0042, 4'b0010, 3'd2, 16'h0123, 1'b0, 1'b0, 1'b0);
    tbl[12] = mk(4'hA, 16'h0004, 4'b0001, 3'd1, 16'h0123, 1'b0, 1'b0, 1'b0);
    tbl[13] = mk(4'hA, 16'h0123, 4'b0000, 3'd0, 16'h0123, 1'b0, 1'b0, 1'b0);
    tbl[14] = mk(4'hA, 16'h0123, 4'b0000, 3'd0, 16'h0123, 1'b0, 1'b0, 1'b0);
    tbl[15] = mk(4'hE, 16'h0123, 4'b0000, 3'd0, 16'h0123, 1'b0, 1'b0, 1'b0);
    tbl[16] = mk(4'hC, 16'h0123, 4'b0000, 3'd0, 16'h0123, 1'b0, 1'b0, 1'b0);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    exp_q.push_back(mk(4'h0, 16'h0000, 4'b0000, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0));
    compare_front("reset");
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Table-driven editing sequence
    for (int i = 0; i < 17; i++) begin
      apply(tbl[i], $sformatf("vec%0d", i));
    end

    // Timeout after 100 idle cycles in ENTRY
    send_only(mk(4'h7, 16'h0007, 4'b0001, 3'd1, 16'h0123, 1'b0, 1'b0, 1'b0));
    compare_front("to_entry");
    key_pressed = 1'b0;
    repeat (99) @(posedge clk);
    #1;
    chk("to_before.to", 16'(timeout), 16'(0));
    chk("to_before.bcd", bcd_out, 16'h0007);
    @(posedge clk);
    #1;
    exp_q.push_back(mk(4'h0, 16'h0123, 4'b0000, 3'd0, 16'h0123, 1'b0, 1'b0, 1'b1));
    compare_front("to_fire");
    @(posedge clk);
    #1;
    check_no_pulse("to_after");

    // Key lands on the exact expiry cycle: key wins, timer reloads
    send_only(mk(4'h7, 16'h0007, 4'b0001, 3'd1, 16'h0123, 1'b0, 1'b0, 1'b0));
    compare_front("tie_entry");
    key_pressed = 1'b0;
    repeat (97) @(posedge clk);
    send_only(mk(4'h3, 16'h0073, 4'b0010, 3'd2, 16'h0123, 1'b0, 1'b0, 1'b0));
    compare_front("tie_key");
    key_pressed = 1'b0;
    @(posedge clk);
    #1;
    check_no_pulse("tie_after");
    chk("tie_after.bcd", bcd_out, 16'h0073);
    repeat (6) @(posedge clk);
    apply(mk(4'hB, 16'h0123, 4'b0000, 3'd0, 16'h0123, 1'b0, 1'b0, 1'b0), "tie_clr");

    // Bounce: two rising edges within 3 cycles give a single event
    exp_q.push_back(mk(4'h5, 16'h0005, 4'b0001, 3'd1, 16'h0123, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    key_num     = 4'h5;
    key_pressed = 1'b1;
    exp_press   = exp_press + 4'd1;
    @(negedge clk);
    key_pressed = 1'b0;
    @(negedge clk);
    key_pressed = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    compare_front("bounce");
    key_pressed = 1'b0;
    repeat (8) @(posedge clk);
    apply(mk(4'hB, 16'h0123, 4'b0000, 3'd0, 16'h0123, 1'b0, 1'b0, 1'b0), "bounce_clr");

    // press_cnt wraps 15 -> 0
    begin
      int n;
      n = 16 - int'(exp_press);
      for (int i = 0; i < n; i++) begin
        apply(mk(4'hD, 16'h0123, 4'b0000, 3'd0, 16'h0123, 1'b0, 1'b0, 1'b0), "wrap");
      end
      chk("press_wrap", 16'(press_cnt), 16'(0));
    end

    // Asynchronous reset in the middle of an entry
    apply(mk(4'h3, 16'h0003, 4'b0001, 3'd1, 16'h0123, 1'b0, 1'b0, 1'b0), "rst_d1");
    apply(mk(4'h4, 16'h0034, 4'b0010, 3'd2, 16'h0123, 1'b0, 1'b0, 1'b0), "rst_d2");
    @(negedge clk);
    #2;
    reset     = 1'b0;
    exp_press = 4'd0;
    #1;
    exp_q.push_back(mk(4'h0, 16'h0000, 4'b0000, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0));
    compare_front("rst_async");
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hold.vv", 16'(value_valid), 16'(0));
    chk("rst_hold.bcd", bcd_out, 16'h0000);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    apply(mk(4'h9, 16'h0009, 4'b0001, 3'd1, 16'h0000, 1'b0, 1'b0, 1'b0), "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
